// File: rtl/instruction_encoder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instruction_encoder_if : request and output-queue bundle of the encoder
// Revision 1.0
// ----------------------------------------------------------------------------
interface instruction_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  err_count;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_count
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_count
  );
endinterface
`default_nettype wire

// File: rtl/instruction_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instruction_encoder : packs RV32I fields into instruction words, queued with
//                       sequential addresses for instruction-memory loading
// Revision 1.0
// ----------------------------------------------------------------------------
module instruction_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  wire logic             clk,
  input  wire logic             rst,
  instruction_encoder_if.slave  enc_if
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

  localparam logic [6:0] C_OP_R    = 7'b0110011;
  localparam logic [6:0] C_OP_LOAD = 7'b0000011;
  localparam logic [6:0] C_OP_JALR = 7'b1100111;
  localparam logic [6:0] C_OP_IMM  = 7'b0010011;
  localparam logic [6:0] C_OP_S    = 7'b0100011;
  localparam logic [6:0] C_OP_B    = 7'b1100011;
  localparam logic [6:0] C_OP_LUI  = 7'b0110111;
  localparam logic [6:0] C_OP_AUI  = 7'b0010111;
  localparam logic [6:0] C_OP_J    = 7'b1101111;

  logic [31:0] instr_mem_q [FIFO_DEPTH];
  logic [31:0] addr_mem_q  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   addr_ctr_q;
  logic          err_q;
  logic [7:0]    err_cnt_q;

  logic [31:0] word_enc;
  logic        legal_enc;
  logic        fits12, fits13, fits21;
  logic        accept, push, pop;
  logic [31:0] imm;
  logic [6:0]  op;

  assign imm = enc_if.in_imm;
  assign op  = enc_if.in_opcode;

  // Signed range checks: upper bits must be a pure sign extension.
  assign fits12 = (&imm[31:11]) | (~|imm[31:11]);
  assign fits13 = (&imm[31:12]) | (~|imm[31:12]);
  assign fits21 = (&imm[31:20]) | (~|imm[31:20]);

  always_comb begin
    word_enc  = 32'h0;
    legal_enc = 1'b0;
    case (op)
      C_OP_R: begin
        word_enc  = {enc_if.in_funct7, enc_if.in_rs2, enc_if.in_rs1,
                     enc_if.in_funct3, enc_if.in_rd, op};
        legal_enc = 1'b1;
      end
      C_OP_LOAD, C_OP_JALR, C_OP_IMM: begin
        word_enc  = {imm[11:0], enc_if.in_rs1, enc_if.in_funct3,
                     enc_if.in_rd, op};
        legal_enc = fits12;
      end
      C_OP_S: begin
        word_enc  = {imm[11:5], enc_if.in_rs2, enc_if.in_rs1,
                     enc_if.in_funct3, imm[4:0], op};
        legal_enc = fits12;
      end
      C_OP_B: begin
        word_enc  = {imm[12], imm[10:5], enc_if.in_rs2, enc_if.in_rs1,
                     enc_if.in_funct3, imm[4:1], imm[11], op};
        legal_enc = fits13 & ~imm[0];
      end
      C_OP_LUI, C_OP_AUI: begin
        word_enc  = {imm[31:12], enc_if.in_rd, op};
        legal_enc = ~|imm[11:0];
      end
      C_OP_J: begin
        word_enc  = {imm[20], imm[10:1], imm[11], imm[19:12],
                     enc_if.in_rd, op};
        legal_enc = fits21 & ~imm[0];
      end
      default: begin
        word_enc  = 32'h0;
        legal_enc = 1'b0;
      end
    endcase
  end

  assign enc_if.in_ready  = (count_q != C_DEPTH);
  assign enc_if.out_valid = (count_q != '0);
  assign accept = enc_if.in_valid & enc_if.in_ready;
  assign push   = accept & legal_enc;
  assign pop    = enc_if.out_valid & enc_if.out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= 32'h0;
        addr_mem_q[i]  <= 32'h0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_ctr_q <= BASE_ADDR;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      count_q <= count_d;
      err_q   <= accept & ~legal_enc;
      if (push) begin
        instr_mem_q[wr_ptr_q] <= word_enc;
        addr_mem_q[wr_ptr_q]  <= addr_ctr_q;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
        addr_ctr_q            <= addr_ctr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (accept && !legal_enc && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign enc_if.out_instr = instr_mem_q[rd_ptr_q];
  assign enc_if.out_addr  = addr_mem_q[rd_ptr_q];
  assign enc_if.err       = err_q;
  assign enc_if.err_count = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instruction_encoder : directed self-checking bench for instruction_encoder
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_instruction_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instruction_encoder_if bus ();

  instruction_encoder #(
    .FIFO_DEPTH (4),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enc_if (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic send(input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 00000000", bus.out_instr); end
    checks++; if (bus.out_addr !== 32'h0) begin errors++; $display("FAIL reset_out_addr: got %h expected 00000000", bus.out_addr); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", bus.err_count); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got ready=%b valid=%b expected ready=1 valid=0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_addi();
    do_reset();
    bus.out_ready = 1'b1;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h00500093) begin errors++; $display("FAIL addi_instr: got %h expected 00500093", bus.out_instr); end
    checks++; if (bus.out_addr !== 32'h0) begin errors++; $display("FAIL addi_addr: got %h expected 00000000", bus.out_addr); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL addi_err: got %b expected 0", bus.err); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addi_drained: got %b expected 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_formats();
    // Unused fields carry junk to show they never leak into the word.
    logic [6:0]  op  [6] = '{7'h23, 7'h6F, 7'h37, 7'h33, 7'h33, 7'h63};
    logic [4:0]  rd  [6] = '{5'd31, 5'd1, 5'd5, 5'd3, 5'd3, 5'd31};
    logic [4:0]  rs1 [6] = '{5'd3, 5'd7, 5'd31, 5'd1, 5'd1, 5'd1};
    logic [4:0]  rs2 [6] = '{5'd2, 5'd9, 5'd31, 5'd2, 5'd2, 5'd2};
    logic [2:0]  f3  [6] = '{3'd2, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0};
    logic [6:0]  f7  [6] = '{7'h55, 7'h7F, 7'h7F, 7'h00, 7'h20, 7'h7F};
    logic [31:0] imm [6] = '{32'hFFFFFFFC, 32'd8, 32'h12345000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFF8};
    logic [31:0] exp [6] = '{32'hFE21AE23, 32'h008000EF, 32'h123452B7, 32'h002081B3, 32'h402081B3, 32'hFE208CE3};
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(op[i], rd[i], rs1[i], rs2[i], f3[i], f7[i], imm[i]);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[i]) begin errors++; $display("FAIL formats_instr[%0d]: got valid=%b %h expected valid=1 %h", i, bus.out_valid, bus.out_instr, exp[i]); end
      checks++; if (bus.out_addr !== 32'(i * 4)) begin errors++; $display("FAIL formats_addr[%0d]: got %h expected %h", i, bus.out_addr, 32'(i * 4)); end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [6:0]  op  [3] = '{7'h63, 7'h13, 7'h7F};
    logic [31:0] imm [3] = '{32'd3, 32'd4096, 32'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(op[i], 5'd1, 5'd1, 5'd2, 3'd0, 7'h00, imm[i]);
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_err[%0d]: got %b expected 1", i, bus.err); end
      checks++; if (bus.err_count !== 8'(i + 1)) begin errors++; $display("FAIL illegal_count[%0d]: got %0d expected %0d", i, bus.err_count, i + 1); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL illegal_enqueued[%0d]: got %b expected 0", i, bus.out_valid); end
    end
    @(posedge clk);
    #1;
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal_err_drop: got %b expected 0", bus.err); end
    // Range extremes: -2048 and 4094 are legal, 4096 and an odd J offset are not.
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL boundary_legal_err: got %b expected 0", bus.err); end
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
    checks++; if (bus.err !== 1'b1 || bus.err_count !== 8'd5) begin errors++; $display("FAIL boundary_illegal: got err=%b count=%0d expected err=1 count=5", bus.err, bus.err_count); end
    bus.out_ready = 1'b1;
    checks++; if (bus.out_instr !== 32'h80000093 || bus.out_addr !== 32'h0) begin errors++; $display("FAIL boundary_word0: got %h @%h expected 80000093 @00000000", bus.out_instr, bus.out_addr); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_instr !== 32'h7E000FE3 || bus.out_addr !== 32'h4) begin errors++; $display("FAIL boundary_word1: got %h @%h expected 7e000fe3 @00000004", bus.out_instr, bus.out_addr); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL boundary_drained: got %b expected 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] exp [5] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093, 32'h00500093};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'(i + 1));
      checks++; if (bus.in_ready !== (i < 3 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL full_ready[%0d]: got %b expected %b", i, bus.in_ready, (i < 3 ? 1'b1 : 1'b0)); end
    end
    bus.in_opcode = 7'h13; bus.in_rd = 5'd1; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
    bus.in_funct3 = 3'd0; bus.in_funct7 = 7'h00; bus.in_imm = 32'd5;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready: got %b expected 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_refill_ready: got %b expected 0", bus.in_ready); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[i] || bus.out_addr !== 32'(i * 4)) begin errors++; $display("FAIL full_order[%0d]: got valid=%b %h @%h expected valid=1 %h @%h", i, bus.out_valid, bus.out_instr, bus.out_addr, exp[i], 32'(i * 4)); end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) send(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
    checks++; if (bus.err_count !== 8'd5 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre: got count=%0d valid=%b expected count=5 valid=1", bus.err_count, bus.out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.err_count !== 8'd0) begin errors++; $display("FAIL midreset_async: got valid=%b count=%0d expected valid=0 count=0", bus.out_valid, bus.err_count); end
    checks++; if (bus.out_instr !== 32'h0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_outputs: got instr=%h ready=%b expected instr=00000000 ready=1", bus.out_instr, bus.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_release: got %b expected 0", bus.out_valid); end
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7);
    checks++; if (bus.out_instr !== 32'h00700093 || bus.out_addr !== 32'h0) begin errors++; $display("FAIL midreset_next: got %h @%h expected 00700093 @00000000", bus.out_instr, bus.out_addr); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.in_opcode = 7'h7F; bus.in_imm = 32'd0;
    bus.in_valid  = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    checks++; if (bus.err_count !== 8'd255 || bus.err !== 1'b1) begin errors++; $display("FAIL sat_reach: got count=%0d err=%b expected count=255 err=1", bus.err_count, bus.err); end
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.err_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", bus.err_count); end
    @(posedge clk);
    #1;
    checks++; if (bus.err !== 1'b0 || bus.err_count !== 8'd255 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL sat_idle: got err=%b count=%0d valid=%b expected err=0 count=255 valid=0", bus.err, bus.err_count, bus.out_valid); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_opcode = 7'h0; bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
    bus.in_funct3 = 3'd0; bus.in_funct7 = 7'h0; bus.in_imm = 32'h0;
    test_reset();
    test_addi();
    test_formats();
    test_illegal();
    test_full();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
